// File: rtl/md_unit_pkg.sv
// Shared MIPS definitions for the multiply/divide unit.
// Holds the operation encoding and a start-op classifier.
package mips_defs;

  localparam int MD_OP_W = 3;

  typedef enum logic [MD_OP_W-1:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  // True for the ops that occupy the unit for several cycles.
  function automatic logic md_is_start(input logic [MD_OP_W-1:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_compute.sv
// Combinational multiply/divide datapath producing the {hi, lo} pair,
// including the MIPS divide-by-zero and MIN/-1 overflow results.
module md_compute
  import mips_defs::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [MD_OP_W-1:0]  op,
  input  logic [WIDTH-1:0]    a,
  input  logic [WIDTH-1:0]    b,
  output logic [2*WIDTH-1:0]  result
);

  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONES    = {WIDTH{1'b1}};

  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag, q_mag, r_mag, q_s, r_s, q_u, r_u;
  logic               b_zero, s_ovf;

  assign a_sx = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx = {{WIDTH{1'b0}}, a};
  assign b_zx = {{WIDTH{1'b0}}, b};

  // The low 2*WIDTH bits of a sign-extended product are the signed product.
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Signed divide via magnitudes so quotient truncates toward zero and the
  // remainder follows the dividend sign.
  assign a_neg = a[WIDTH-1];
  assign b_neg = b[WIDTH-1];
  assign a_mag = a_neg ? (~a + 1'b1) : a;
  assign b_mag = b_neg ? (~b + 1'b1) : b;
  assign q_mag = b_zero ? '0 : (a_mag / b_mag);
  assign r_mag = b_zero ? '0 : (a_mag % b_mag);
  assign q_s   = (a_neg ^ b_neg) ? (~q_mag + 1'b1) : q_mag;
  assign r_s   = a_neg ? (~r_mag + 1'b1) : r_mag;
  assign q_u   = b_zero ? '0 : (a / b);
  assign r_u   = b_zero ? '0 : (a % b);

  assign b_zero = (b == '0);
  assign s_ovf  = (a == MIN_VAL) && (b == ONES);

  always_comb begin
    result = '0;
    case (op)
      MD_MULT:  result = prod_s;
      MD_MULTU: result = prod_u;
      MD_DIV: begin
        if (b_zero)     result = {a, ONES};
        else if (s_ovf) result = {{WIDTH{1'b0}}, MIN_VAL};
        else            result = {r_s, q_s};
      end
      MD_DIVU: begin
        if (b_zero) result = {a, ONES};
        else        result = {r_u, q_u};
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// EX-stage multiply/divide unit owning HI/LO: results are computed at
// acceptance, held in a shadow pair, and committed after a fixed latency.
module md_unit
  import mips_defs::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               op_valid,
  input  logic [MD_OP_W-1:0] op,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               cancel,
  input  logic               id_uses_md,
  output logic               busy,
  output logic               stall,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] shadow_q, result;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               is_start, is_mul, start;

  md_compute #(.WIDTH(WIDTH)) u_compute (
    .op     (op),
    .a      (src_a),
    .b      (src_b),
    .result (result)
  );

  assign is_start = md_is_start(op);
  assign is_mul   = (op == MD_MULT) || (op == MD_MULTU);
  assign start    = op_valid && !cancel && is_start;
  assign cnt_d    = cnt_q - 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      shadow_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            shadow_q <= result;
            cnt_q    <= is_mul ? MULT_LOAD : DIV_LOAD;
            state_q  <= S_RUN;
          end else if (op_valid && !cancel && (op == MD_MTHI)) begin
            hi_q <= src_a;
          end else if (op_valid && !cancel && (op == MD_MTLO)) begin
            lo_q <= src_a;
          end
        end
        S_RUN: begin
          // A flush wins over a commit landing on the same edge.
          if (cancel) begin
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else if (cnt_q == CNT_LAST) begin
            hi_q    <= shadow_q[2*WIDTH-1:WIDTH];
            lo_q    <= shadow_q[WIDTH-1:0];
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy  = (state_q == S_RUN);
  assign stall = id_uses_md && (busy || start);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a vector table for the arithmetic plus
// hand sequences for stall, cancel, reset and a 1-cycle 16-bit instance.
module tb_md_unit;
  import mips_defs::*;

  logic        clk = 1'b0;
  logic        reset, op_valid, cancel, id_uses_md;
  logic [2:0]  op;
  logic [31:0] src_a, src_b;
  logic        busy, stall;
  logic [31:0] hi, lo;

  logic        r16_reset, v16, c16, u16_id;
  logic [2:0]  op16;
  logic [15:0] a16, b16;
  logic        busy16, stall16;
  logic [15:0] hi16, lo16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel), .id_uses_md(id_uses_md),
    .busy(busy), .stall(stall), .hi(hi), .lo(lo)
  );

  md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut16 (
    .clk(clk), .reset(r16_reset), .op_valid(v16), .op(op16),
    .src_a(a16), .src_b(b16), .cancel(c16), .id_uses_md(u16_id),
    .busy(busy16), .stall(stall16), .hi(hi16), .lo(lo16)
  );

  // The hazard logic must never issue into a busy unit.
  always @(posedge clk) begin
    if (!reset && op_valid && busy && !cancel) begin
      checks++; errors++;
      $display("FAIL issue_while_busy32: op_valid=1 while busy=1");
    end
    if (!r16_reset && v16 && busy16 && !c16) begin
      checks++; errors++;
      $display("FAIL issue_while_busy16: op_valid=1 while busy=1");
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int n);
    @(negedge clk);
    op_valid = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    op_valid = 1'b0;
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic stall_ok;

    vecs[0]  = '{MD_MULT,  32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1]  = '{MD_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF, 10};
    vecs[2]  = '{MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[3]  = '{MD_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[4]  = '{MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[5]  = '{MD_DIVU,  32'd100,      32'd7,        32'd2,        32'd14,       10};
    vecs[6]  = '{MD_DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 10};
    vecs[7]  = '{MD_DIV,   32'd0,        32'd0,        32'd0,        32'hFFFFFFFF, 10};
    vecs[8]  = '{MD_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
    vecs[9]  = '{MD_MULTU, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 5};
    vecs[10] = '{MD_DIVU,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, 10};

    reset = 1'b1; op_valid = 1'b0; cancel = 1'b0; id_uses_md = 1'b0;
    op = 3'd0; src_a = '0; src_b = '0;
    r16_reset = 1'b1; v16 = 1'b0; c16 = 1'b0; u16_id = 1'b0;
    op16 = 3'd0; a16 = '0; b16 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0; r16_reset = 1'b0;

    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_hi", 64'(hi), 64'd0);
    chk("reset_lo", 64'(lo), 64'd0);
    chk("reset_stall", 64'(stall), 64'd0);

    for (int i = 0; i < 11; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, n);
      chk($sformatf("vec%0d_cycles", i), 64'(n), 64'(vecs[i].cyc));
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
    end

    // Stall from the issue cycle until the commit edge.
    id_uses_md = 1'b1;
    @(negedge clk);
    op_valid = 1'b1; op = MD_DIV; src_a = 32'hFFFFFFF9; src_b = 32'd2;
    #1 chk("stall_issue_cycle", 64'(stall), 64'd1);
    @(negedge clk);
    op_valid = 1'b0;
    n = 0; stall_ok = 1'b1;
    while (busy && n < 50) begin
      if (!stall) stall_ok = 1'b0;
      n++;
      @(negedge clk);
    end
    chk("stall_while_busy", 64'(stall_ok), 64'd1);
    chk("stall_cycles", 64'(n), 64'd10);
    chk("stall_after_commit", 64'(stall), 64'd0);
    chk("stall_div_lo", 64'(lo), 64'hFFFFFFFD);
    id_uses_md = 1'b0;

    // Cancel at cycle 3 of a MULTU, then MTLO.
    @(negedge clk);
    op_valid = 1'b1; op = MD_MULTU; src_a = 32'hFFFFFFFF; src_b = 32'hFFFFFFFF;
    @(negedge clk);
    op_valid = 1'b0;
    chk("cancel_busy_before", 64'(busy), 64'd1);
    chk("no_stall_without_id", 64'(stall), 64'd0);
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy_after", 64'(busy), 64'd0);
    chk("cancel_hi_kept", 64'(hi), 64'hFFFFFFFF);
    chk("cancel_lo_kept", 64'(lo), 64'hFFFFFFFD);
    op_valid = 1'b1; op = MD_MTLO; src_a = 32'h00001234;
    @(negedge clk);
    op_valid = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'h1234);
    chk("mtlo_hi_kept", 64'(hi), 64'hFFFFFFFF);
    chk("mtlo_no_busy", 64'(busy), 64'd0);
    repeat (8) @(negedge clk);
    chk("cancel_no_late_hi", 64'(hi), 64'hFFFFFFFF);
    chk("cancel_no_late_lo", 64'(lo), 64'h1234);

    // Cancel coinciding with the commit edge suppresses the write.
    @(negedge clk);
    op_valid = 1'b1; op = MD_MULT; src_a = 32'd3; src_b = 32'd4;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("commit_cancel_busy_pre", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("commit_cancel_busy", 64'(busy), 64'd0);
    chk("commit_cancel_hi", 64'(hi), 64'hFFFFFFFF);
    chk("commit_cancel_lo", 64'(lo), 64'h1234);

    // MTHI discarded by cancel, then accepted; unused op ignored.
    op_valid = 1'b1; op = MD_MTHI; src_a = 32'h0000AAAA; cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    op_valid = 1'b0;
    chk("mthi_cancelled", 64'(hi), 64'hFFFFFFFF);
    op_valid = 1'b1; op = MD_MTHI; src_a = 32'hCAFE0000;
    @(negedge clk);
    op_valid = 1'b1; op = 3'd7; src_a = 32'h55555555; src_b = 32'd1;
    chk("mthi_hi", 64'(hi), 64'hCAFE0000);
    @(negedge clk);
    op_valid = 1'b0;
    chk("unused_op_hi", 64'(hi), 64'hCAFE0000);
    chk("unused_op_lo", 64'(lo), 64'h1234);
    chk("unused_op_busy", 64'(busy), 64'd0);

    // Reset during a DIV clears everything and suppresses the commit.
    @(negedge clk);
    op_valid = 1'b1; op = MD_DIVU; src_a = 32'd100; src_b = 32'd7;
    @(negedge clk);
    op_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_hi", 64'(hi), 64'd0);
    chk("midreset_lo", 64'(lo), 64'd0);
    chk("midreset_busy", 64'(busy), 64'd0);
    repeat (12) @(negedge clk);
    chk("midreset_no_commit_hi", 64'(hi), 64'd0);
    chk("midreset_no_commit_lo", 64'(lo), 64'd0);

    // 16-bit, 1-cycle instance: back-to-back starts every second cycle.
    @(negedge clk);
    v16 = 1'b1; op16 = MD_MULT; a16 = 16'h8000; b16 = 16'h0002;
    @(negedge clk);
    v16 = 1'b0;
    chk("w16_mult_busy", 64'(busy16), 64'd1);
    @(negedge clk);
    chk("w16_mult_done", 64'(busy16), 64'd0);
    chk("w16_mult_hi", 64'(hi16), 64'hFFFF);
    chk("w16_mult_lo", 64'(lo16), 64'h0000);
    v16 = 1'b1; op16 = MD_MULTU; a16 = 16'hFFFF; b16 = 16'hFFFF;
    @(negedge clk);
    v16 = 1'b0;
    chk("w16_multu_busy", 64'(busy16), 64'd1);
    @(negedge clk);
    chk("w16_multu_hi", 64'(hi16), 64'hFFFE);
    chk("w16_multu_lo", 64'(lo16), 64'h0001);
    v16 = 1'b1; op16 = MD_DIV; a16 = 16'h8000; b16 = 16'hFFFF;
    @(negedge clk);
    v16 = 1'b0;
    chk("w16_div_busy", 64'(busy16), 64'd1);
    @(negedge clk);
    chk("w16_div_done", 64'(busy16), 64'd0);
    chk("w16_div_hi", 64'(hi16), 64'h0000);
    chk("w16_div_lo", 64'(lo16), 64'h8000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
